pcpi_dispatch: RTL and testbench
================================

Name: pcpi_dispatch

Overview:
- Sits between the core's PCPI master port and the coprocessors (MUL unit on slot 0, DIV unit on slot 1, custom-0 accelerators on slots 2 and up).
- Decodes the instruction on the core's PCPI bus and forwards the request to exactly one slave.
- Runs a per-request watchdog.
- Returns a registered, single-cycle response to the core.

Parameters:
- NUM_SLV, 2, number of slave slots; legal range 2..10.
- TIMEOUT, 16, cycles allowed in BUSY without the selected slave's wait or ready before abort; legal range 2..255.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- pcpi_valid  in  1  core request valid; held until ready or abort
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  32  operand 1
- pcpi_rs2  in  32  operand 2
- pcpi_wr  out  1  write-back enable; qualified by pcpi_ready
- pcpi_rd  out  32  result
- pcpi_wait  out  1  slave busy indication to the core
- pcpi_ready  out  1  one-cycle completion pulse
- s_valid  out  NUM_SLV  per-slave request; one-hot or zero
- s_insn  out  32  broadcast of pcpi_insn
- s_rs1  out  32  broadcast of pcpi_rs1
- s_rs2  out  32  broadcast of pcpi_rs2
- s_wr  in  NUM_SLV  per-slave write enable
- s_rd  in  32*NUM_SLV  per-slave result; slot k occupies bits [32k+31:32k]
- s_wait  in  NUM_SLV  per-slave wait
- s_ready  in  NUM_SLV  per-slave ready
- err_undecoded  out  1  one-cycle pulse: no slot matched
- err_timeout  out  1  one-cycle pulse: watchdog expired

Behaviour:
- Decode:
  - Slot 0: opcode 0110011, funct7 0000001, funct3[2]=0.
  - Slot 1: same opcode and funct7, funct3[2]=1.
  - Slot k>=2: opcode 0001011, funct3 = k-2.
  - Anything else: no match.
- s_insn, s_rs1, s_rs2 are combinational pass-throughs.
- Reset (resetn=0 at an edge):
  - state=IDLE.
  - pcpi_wr, pcpi_ready, pcpi_rd, s_valid, err_undecoded, err_timeout all 0.
  - Watchdog counter 0.
  - Reset mid-operation discards the request; no response is produced.
- States:
  - IDLE:
    - pcpi_valid=1 and a slot matches: latch one-hot sel, clear counter, go BUSY.
    - pcpi_valid=1 and no match: err_undecoded=1 for one cycle, go DRAIN.
  - BUSY:
    - s_valid = sel (registered).
    - pcpi_wait = |(s_wait & sel), combinational.
    - Counter increments each cycle in which (s_wait|s_ready)&sel is zero; it holds once wait has been seen.
    - |(s_ready & sel)=1: next edge sets pcpi_ready=1, pcpi_wr = selected s_wr, pcpi_rd = selected s_rd, s_valid=0; go DRAIN.
    - Counter reaches TIMEOUT with no ready: err_timeout=1 for one cycle, s_valid=0, go DRAIN.
    - pcpi_valid=0 (core abort): s_valid=0, go IDLE; no response.
  - DRAIN:
    - All s_valid=0, pcpi_wait=0.
    - Return to IDLE on the first cycle with pcpi_valid=0.
    - Prevents re-issue of the same held instruction.
- Latency:
  - Core valid at cycle 0 gives s_valid at cycle 1.
  - Slave ready at cycle t gives pcpi_ready at cycle t+1.
  - Minimum request-to-response is slave latency + 2.
- pcpi_ready, pcpi_wr, err_* are always single-cycle pulses. pcpi_rd holds its value until the next response.
- Simultaneous events:
  - Selected ready in the same cycle as watchdog expiry: ready wins, no err_timeout.
  - Selected ready in the same cycle as pcpi_valid falling: abort wins, response dropped.
- s_ready, s_wait, s_wr from unselected slots are ignored in every state.
- s_valid is never multi-hot.

Decomposition:
- Shared package pcpi_pkg:
  - Opcode constants OPC_OP=7'b0110011, OPC_CUSTOM0=7'b0001011.
  - FUNCT7_MULDIV=7'b0000001.
  - State encoding IDLE/BUSY/DRAIN.
  - SLOT_MUL=0, SLOT_DIV=1.
- One combinational sub-module pcpi_slot_decode: insn in, NUM_SLV-bit one-hot match out plus a hit flag.
- FSM, watchdog and response mux stay in pcpi_dispatch.

Test Plan:
- Slot 0 wired to the MUL unit: MUL with rs1=7, rs2=6. Expect s_valid=01 at cycle 1, pcpi_ready single pulse, pcpi_wr=1, pcpi_rd=42, s_valid back to 0 on the same edge as the pulse.
- MULHU with rs1=rs2=0xFFFFFFFF: pcpi_rd=0xFFFFFFFE. Then hold pcpi_valid for 3 more cycles: no second s_valid until valid drops and rises again.
- ADD (funct7=0000000): err_undecoded pulses at cycle 1, s_valid stays 0, pcpi_ready never asserts, FSM returns to IDLE when valid drops.
- Stub slave on slot 1 that never waits or readies, TIMEOUT=16, DIV insn: err_timeout pulses after 16 BUSY cycles, s_valid falls with it, pcpi_wait never asserts.
- Slot 0 waiting; core drops pcpi_valid mid-BUSY; stub then pulses s_ready=1 with s_rd=0xDEADBEEF: s_valid=0 the next cycle, no pcpi_ready, pcpi_rd unchanged.
- resetn=0 for one cycle while BUSY with slot 1 selected: all outputs 0 after the edge. A fresh MUL 3*5 then returns pcpi_rd=15.

Source files
------------

// File: rtl/pcpi_pkg.sv
// Shared constants, state encoding and field helpers for the PCPI dispatcher.
// Imported by the slot decoder and the dispatcher top.
package pcpi_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_CUSTOM0   = 7'b0001011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam int SLOT_MUL = 0;
    localparam int SLOT_DIV = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } pcpi_state_e;

    function automatic logic [6:0] insn_opcode(input logic [31:0] insn);
        return insn[6:0];
    endfunction

    function automatic logic [2:0] insn_funct3(input logic [31:0] insn);
        return insn[14:12];
    endfunction

    function automatic logic [6:0] insn_funct7(input logic [31:0] insn);
        return insn[31:25];
    endfunction

endpackage

// File: rtl/pcpi_slot_decode.sv
// Combinational slot decoder: maps an instruction word to a one-hot slot match.
// MUL/DIV share OP+MULDIV funct7 and split on funct3[2]; custom-0 slots use funct3.
module pcpi_slot_decode
    import pcpi_pkg::*;
#(
    parameter int NUM_SLV = 2
) (
    input  logic [31:0]        insn,
    output logic [NUM_SLV-1:0] match,
    output logic               hit
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       is_muldiv;
    logic       is_custom0;
    logic       unused_insn_bits;

    assign opcode     = insn_opcode(insn);
    assign funct7     = insn_funct7(insn);
    assign funct3     = insn_funct3(insn);
    assign is_muldiv  = (opcode == OPC_OP) && (funct7 == FUNCT7_MULDIV);
    assign is_custom0 = (opcode == OPC_CUSTOM0);

    // Register-specifier fields play no part in slot selection.
    assign unused_insn_bits = ^{insn[24:15], insn[11:7]};

    always_comb begin
        match           = '0;
        match[SLOT_MUL] = is_muldiv && !funct3[2];
        match[SLOT_DIV] = is_muldiv && funct3[2];
        for (int k = 2; k < NUM_SLV; k++) begin
            match[k] = is_custom0 && (funct3 == 3'(k - 2));
        end
    end

    assign hit = |match;

endmodule

// File: rtl/pcpi_dispatch.sv
// PCPI dispatcher: decodes the core request, forwards it to one coprocessor slot,
// runs a per-request watchdog and returns a registered single-cycle response.
module pcpi_dispatch
    import pcpi_pkg::*;
#(
    parameter int NUM_SLV = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pcpi_valid,
    input  logic [31:0]           pcpi_insn,
    input  logic [31:0]           pcpi_rs1,
    input  logic [31:0]           pcpi_rs2,
    output logic                  pcpi_wr,
    output logic [31:0]           pcpi_rd,
    output logic                  pcpi_wait,
    output logic                  pcpi_ready,
    output logic [NUM_SLV-1:0]    s_valid,
    output logic [31:0]           s_insn,
    output logic [31:0]           s_rs1,
    output logic [31:0]           s_rs2,
    input  logic [NUM_SLV-1:0]    s_wr,
    input  logic [32*NUM_SLV-1:0] s_rd,
    input  logic [NUM_SLV-1:0]    s_wait,
    input  logic [NUM_SLV-1:0]    s_ready,
    output logic                  err_undecoded,
    output logic                  err_timeout
);

    localparam int CW = 8;

    // Handshake: the core holds pcpi_valid until pcpi_ready or until it drops
    // valid itself (abort). A slave sees s_valid for as long as the request is
    // outstanding and completes it with a one-cycle s_ready, sampled here on the
    // rising edge; everything from unselected slots is masked off by sel.

    pcpi_state_e        state, state_d;
    logic [NUM_SLV-1:0] sel, sel_d;
    logic [NUM_SLV-1:0] dec_match;
    logic               dec_hit;
    logic [CW-1:0]      cnt, cnt_d;
    logic               wait_seen, wait_seen_d;
    logic               ready_d, wr_d, err_u_d, err_t_d;
    logic [31:0]        rd_d, sel_rd;
    logic               sel_wr, sel_wait, sel_ready;

    pcpi_slot_decode #(
        .NUM_SLV (NUM_SLV)
    ) u_slot_decode (
        .insn  (pcpi_insn),
        .match (dec_match),
        .hit   (dec_hit)
    );

    assign s_insn = pcpi_insn;
    assign s_rs1  = pcpi_rs1;
    assign s_rs2  = pcpi_rs2;

    assign s_valid   = (state == BUSY) ? sel : '0;
    assign sel_wait  = |(s_wait & sel);
    assign sel_ready = |(s_ready & sel);
    assign sel_wr    = |(s_wr & sel);
    assign pcpi_wait = (state == BUSY) && sel_wait;

    always_comb begin
        sel_rd = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (sel[k]) begin
                sel_rd = sel_rd | s_rd[32*k +: 32];
            end
        end
    end

    // Abort beats ready, and ready beats watchdog expiry. Once the slave has
    // signalled wait it owns the request, so the watchdog stops counting.
    always_comb begin
        state_d     = state;
        sel_d       = sel;
        cnt_d       = cnt;
        wait_seen_d = wait_seen;
        ready_d     = 1'b0;
        wr_d        = 1'b0;
        rd_d        = pcpi_rd;
        err_u_d     = 1'b0;
        err_t_d     = 1'b0;
        case (state)
            IDLE: begin
                if (pcpi_valid) begin
                    if (dec_hit) begin
                        sel_d       = dec_match;
                        cnt_d       = '0;
                        wait_seen_d = 1'b0;
                        state_d     = BUSY;
                    end else begin
                        err_u_d = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            BUSY: begin
                if (!pcpi_valid) begin
                    state_d = IDLE;
                end else if (sel_ready) begin
                    ready_d = 1'b1;
                    wr_d    = sel_wr;
                    rd_d    = sel_rd;
                    state_d = DRAIN;
                end else if (sel_wait || wait_seen) begin
                    wait_seen_d = 1'b1;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    err_t_d = 1'b1;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            DRAIN: begin
                if (!pcpi_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            sel           <= '0;
            cnt           <= '0;
            wait_seen     <= 1'b0;
            pcpi_ready    <= 1'b0;
            pcpi_wr       <= 1'b0;
            pcpi_rd       <= '0;
            err_undecoded <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            state         <= state_d;
            sel           <= sel_d;
            cnt           <= cnt_d;
            wait_seen     <= wait_seen_d;
            pcpi_ready    <= ready_d;
            pcpi_wr       <= wr_d;
            pcpi_rd       <= rd_d;
            err_undecoded <= err_u_d;
            err_timeout   <= err_t_d;
        end
    end

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Self-checking bench for pcpi_dispatch with three slots (MUL, DIV, one custom-0).
// Responses are checked against a queue of expected results filled at issue time.
module tb_pcpi_dispatch;
    import pcpi_pkg::*;

    localparam int NS  = 3;
    localparam int TMO = 16;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             pcpi_valid = 1'b0;
    logic [31:0]      pcpi_insn = '0;
    logic [31:0]      pcpi_rs1 = '0;
    logic [31:0]      pcpi_rs2 = '0;
    logic             pcpi_wr;
    logic [31:0]      pcpi_rd;
    logic             pcpi_wait;
    logic             pcpi_ready;
    logic [NS-1:0]    s_valid;
    logic [31:0]      s_insn, s_rs1, s_rs2;
    logic [NS-1:0]    s_wr = '0;
    logic [32*NS-1:0] s_rd = '0;
    logic [NS-1:0]    s_wait = '0;
    logic [NS-1:0]    s_ready = '0;
    logic             err_undecoded;
    logic             err_timeout;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_wr_q[$];
    logic        prev_ready = 1'b0;

    pcpi_dispatch #(
        .NUM_SLV (NS),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .pcpi_valid    (pcpi_valid),
        .pcpi_insn     (pcpi_insn),
        .pcpi_rs1      (pcpi_rs1),
        .pcpi_rs2      (pcpi_rs2),
        .pcpi_wr       (pcpi_wr),
        .pcpi_rd       (pcpi_rd),
        .pcpi_wait     (pcpi_wait),
        .pcpi_ready    (pcpi_ready),
        .s_valid       (s_valid),
        .s_insn        (s_insn),
        .s_rs1         (s_rs1),
        .s_rs2         (s_rs2),
        .s_wr          (s_wr),
        .s_rd          (s_rd),
        .s_wait        (s_wait),
        .s_ready       (s_ready),
        .err_undecoded (err_undecoded),
        .err_timeout   (err_timeout)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_insn(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    function automatic logic [NS-1:0] oh(input int k);
        logic [NS-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Behavioural MUL/DIV slave arithmetic.
    function automatic logic [31:0] muldiv_model(input logic [31:0] insn, input logic [31:0] a,
                                                 input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (insn[14:12])
            3'b000:  return p[31:0];
            3'b011:  return p[63:32];
            3'b101:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive_rd(input int slot, input logic [31:0] res);
        for (int j = 0; j < NS; j++) begin
            s_rd[32*j +: 32] = (j == slot) ? res : (32'hBAD0_0000 | 32'(j));
        end
    endtask

    // Issue one request, let the slave stall for lat cycles (asserting wait or
    // staying silent), then complete it; unselected slots drive noise throughout.
    task automatic run_req(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                           input int slot, input int lat, input bit use_wait,
                           input logic [31:0] res, input logic wr,
                           input logic [31:0] exp_rd, input int hold);
        pcpi_insn  = insn;
        pcpi_rs1   = rs1;
        pcpi_rs2   = rs2;
        pcpi_valid = 1'b1;
        exp_q.push_back(exp_rd);
        exp_wr_q.push_back(32'(wr));
        @(negedge clk);
        check("s_valid_cycle1", 32'(s_valid), 32'(oh(slot)));
        check("s_insn_pass", s_insn, insn);
        for (int i = 0; i < lat; i++) begin
            s_wait  = use_wait ? '1 : ~oh(slot);
            s_ready = ~oh(slot);
            s_wr    = '1;
            drive_rd(slot, 32'h0);
            #1;
            check("pcpi_wait", 32'(pcpi_wait), 32'(use_wait));
            @(negedge clk);
            check("s_valid_busy", 32'(s_valid), 32'(oh(slot)));
        end
        s_wait  = '0;
        s_ready = '1;
        s_wr    = wr ? oh(slot) : ~oh(slot);
        drive_rd(slot, res);
        @(negedge clk);
        check("pcpi_ready_set", 32'(pcpi_ready), 32'd1);
        check("s_valid_drop", 32'(s_valid), 32'd0);
        check("err_timeout_low", 32'(err_timeout), 32'd0);
        s_ready = '0;
        s_wr    = '0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("s_valid_held", 32'(s_valid), 32'd0);
            check("pcpi_ready_held", 32'(pcpi_ready), 32'd0);
        end
        pcpi_valid = 1'b0;
        @(negedge clk);
        check("pcpi_ready_pulse", 32'(pcpi_ready), 32'd0);
        check("state_idle", 32'(dut.state), 32'(IDLE));
    endtask

    // scoreboard
    always @(negedge clk) begin
        check("s_valid_onehot0", 32'($onehot0(s_valid)), 32'd1);
        if (pcpi_ready) begin
            check("ready_single", 32'(prev_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                check("pcpi_rd", pcpi_rd, exp_q.pop_front());
                check("pcpi_wr", 32'(pcpi_wr), exp_wr_q.pop_front());
            end
        end
        prev_ready = pcpi_ready;
    end

    initial begin
        logic [31:0] insn;
        int          n;
        bit          saw_wait;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(pcpi_ready), 32'd0);
        check("rst_wr", 32'(pcpi_wr), 32'd0);
        check("rst_rd", pcpi_rd, 32'd0);
        check("rst_s_valid", 32'(s_valid), 32'd0);
        check("rst_err_u", 32'(err_undecoded), 32'd0);
        check("rst_err_t", 32'(err_timeout), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // MUL 7*6 with two wait cycles
        insn = r_insn(FUNCT7_MULDIV, 3'b000, OPC_OP);
        run_req(insn, 32'd7, 32'd6, SLOT_MUL, 2, 1'b1,
                muldiv_model(insn, 32'd7, 32'd6), 1'b1, 32'd42, 0);

        // MULHU all-ones, valid held 3 cycles after the response, then reissued
        insn = r_insn(FUNCT7_MULDIV, 3'b011, OPC_OP);
        run_req(insn, 32'hFFFF_FFFF, 32'hFFFF_FFFF, SLOT_MUL, $urandom_range(0, 3), 1'b1,
                muldiv_model(insn, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1, 32'hFFFF_FFFE, 3);
        run_req(insn, 32'hFFFF_FFFF, 32'hFFFF_FFFF, SLOT_MUL, 0, 1'b1,
                muldiv_model(insn, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1, 32'hFFFF_FFFE, 0);

        // ADD and a custom-0 slot beyond NUM_SLV: both undecoded
        for (int t = 0; t < 2; t++) begin
            pcpi_insn  = (t == 0) ? r_insn(7'b0000000, 3'b000, OPC_OP)
                                  : r_insn(7'b0000000, 3'b001, OPC_CUSTOM0);
            pcpi_valid = 1'b1;
            @(negedge clk);
            check("err_undecoded_set", 32'(err_undecoded), 32'd1);
            check("undec_s_valid", 32'(s_valid), 32'd0);
            @(negedge clk);
            check("err_undecoded_pulse", 32'(err_undecoded), 32'd0);
            check("undec_s_valid_drain", 32'(s_valid), 32'd0);
            @(negedge clk);
            pcpi_valid = 1'b0;
            @(negedge clk);
            check("undec_state_idle", 32'(dut.state), 32'(IDLE));
        end

        // custom-0 slot 2, no write-back
        run_req(r_insn(7'b0000000, 3'b000, OPC_CUSTOM0), 32'h1234_0000, 32'h0000_5678, 2,
                1, 1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678, 0);

        // DIVU to a silent slot 1: watchdog expiry
        pcpi_insn  = r_insn(FUNCT7_MULDIV, 3'b101, OPC_OP);
        pcpi_valid = 1'b1;
        s_wait     = ~oh(SLOT_DIV);
        s_ready    = ~oh(SLOT_DIV);
        @(negedge clk);
        check("tmo_s_valid", 32'(s_valid), 32'(oh(SLOT_DIV)));
        n        = 0;
        saw_wait = 1'b0;
        while (n < 40) begin
            #1;
            saw_wait = saw_wait | pcpi_wait;
            @(negedge clk);
            n++;
            if (err_timeout) break;
        end
        check("tmo_cycles", 32'(n), 32'd16);
        check("tmo_err_set", 32'(err_timeout), 32'd1);
        check("tmo_s_valid_drop", 32'(s_valid), 32'd0);
        check("tmo_no_wait", 32'(saw_wait), 32'd0);
        s_wait  = '0;
        s_ready = '0;
        @(negedge clk);
        check("tmo_err_pulse", 32'(err_timeout), 32'd0);
        check("tmo_rd_kept", pcpi_rd, 32'h1234_5678);
        pcpi_valid = 1'b0;
        @(negedge clk);

        // ready in the same cycle the watchdog would expire
        insn = r_insn(FUNCT7_MULDIV, 3'b101, OPC_OP);
        run_req(insn, 32'd100, 32'd7, SLOT_DIV, TMO - 1, 1'b0,
                muldiv_model(insn, 32'd100, 32'd7), 1'b1, 32'd14, 0);

        // core abort in the same cycle as the slave's ready
        pcpi_insn  = r_insn(FUNCT7_MULDIV, 3'b000, OPC_OP);
        pcpi_valid = 1'b1;
        @(negedge clk);
        check("abort_s_valid", 32'(s_valid), 32'(oh(SLOT_MUL)));
        s_wait = oh(SLOT_MUL);
        repeat (2) @(negedge clk);
        pcpi_valid = 1'b0;
        s_wait     = '0;
        s_ready    = oh(SLOT_MUL);
        s_wr       = oh(SLOT_MUL);
        drive_rd(SLOT_MUL, 32'hDEAD_BEEF);
        @(negedge clk);
        check("abort_s_valid_drop", 32'(s_valid), 32'd0);
        check("abort_no_ready", 32'(pcpi_ready), 32'd0);
        check("abort_rd_kept", pcpi_rd, 32'd14);
        s_ready = '0;
        s_wr    = '0;
        @(negedge clk);
        check("abort_no_ready_late", 32'(pcpi_ready), 32'd0);
        check("abort_state_idle", 32'(dut.state), 32'(IDLE));

        // reset while BUSY on slot 1
        pcpi_insn  = r_insn(FUNCT7_MULDIV, 3'b100, OPC_OP);
        pcpi_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_s_valid", 32'(s_valid), 32'(oh(SLOT_DIV)));
        @(negedge clk);
        resetn     = 1'b0;
        pcpi_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_s_valid_clr", 32'(s_valid), 32'd0);
        check("mid_rst_rd_clr", pcpi_rd, 32'd0);
        check("mid_rst_ready", 32'(pcpi_ready), 32'd0);
        check("mid_rst_wr", 32'(pcpi_wr), 32'd0);
        check("mid_rst_wait", 32'(pcpi_wait), 32'd0);
        check("mid_rst_errs", 32'({err_undecoded, err_timeout}), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        insn = r_insn(FUNCT7_MULDIV, 3'b000, OPC_OP);
        run_req(insn, 32'd3, 32'd5, SLOT_MUL, 1, 1'b1,
                muldiv_model(insn, 32'd3, 32'd5), 1'b1, 32'd15, 0);

        repeat (2) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
